// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the control FSM encoding and the divide-ratio clamp.
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    RUN    = 2'd1,
    RELOAD = 2'd2
  } div_state_t;

  localparam int unsigned DIV_MIN = 2;

  // Ratios below DIV_MIN would leave no room for both clock phases.
  // The compare is done on the full zero-extended value, so ratios up to 32 bits wide clamp correctly.
  function automatic logic [31:0] clamp_div(input logic [31:0] value);
    if (value < DIV_MIN) begin
      return DIV_MIN;
    end
    return value;
  endfunction

endpackage

// File: rtl/clk_div_phase.sv
// Phase counter for one divided period, with registered clk_out/tick decode.
// All outputs are computed from next-cycle values so they leave flops directly.
module clk_div_phase #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W:0]   high_len;

  // The registered tick marks count==N-1, so it doubles as the wrap condition.
  always_comb begin
    count_next = '0;
    if (active && run && !tick) begin
      count_next = count + 1'b1;
    end
  end

  // ceil(N/2), one bit wider so N at its maximum cannot overflow.
  assign high_len = ({1'b0, div} + 1'b1) >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      count   <= count_next;
      clk_out <= run && ({1'b0, count_next} < high_len);
      tick    <= run && (count_next == div - 1'b1);
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Programmable integer clock divider: control FSM, ratio/pending registers,
// load handshake and completed-period counter around the phase counter.
module clk_div_gen #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4,
  parameter int PER_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [PER_W-1:0] periods
);

  import clk_div_pkg::*;

  div_state_t       state;
  div_state_t       state_next;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] n_next;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] pending_next;
  logic [CNT_W-1:0] div_clamped;
  logic             accept;
  logic             run_next;

  assign div_clamped = CNT_W'(clamp_div(32'(div_val)));
  assign running     = (state != STOP);
  assign div_ready   = (state != RELOAD);
  assign accept      = div_load && div_ready;
  assign run_next    = (state_next != STOP);

  // A period is never cut short: leaving RUN or RELOAD only happens on tick.
  always_comb begin
    state_next   = state;
    n_next       = n;
    pending_next = pending;
    case (state)
      STOP: begin
        if (accept) begin
          n_next = div_clamped;
        end
        if (en) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (tick && !en) begin
          state_next = STOP;
          if (accept) begin
            n_next = div_clamped;
          end
        end else if (accept) begin
          state_next   = RELOAD;
          pending_next = div_clamped;
        end
      end
      RELOAD: begin
        if (tick) begin
          n_next     = pending;
          state_next = en ? RUN : STOP;
        end
      end
      default: begin
        state_next = STOP;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= STOP;
      n       <= CNT_W'(DEFAULT_DIV);
      pending <= CNT_W'(DEFAULT_DIV);
    end else begin
      state   <= state_next;
      n       <= n_next;
      pending <= pending_next;
    end
  end

  // The phase counter sees the ratio that applies from the next cycle on.
  clk_div_phase #(
    .CNT_W (CNT_W)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .active  (running),
    .run     (run_next),
    .div     (n_next),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      periods <= '0;
    end else if (tick) begin
      periods <= periods + 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen, with a second small-PER_W
// instance used to exercise period-counter wrap.
module tb_clk_div_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div_val;
  logic        div_load;
  logic        div_ready;
  logic        clk_out;
  logic        tick;
  logic        running;
  logic [31:0] periods;

  logic        en_w;
  logic [15:0] div_val_w;
  logic        div_load_w;
  logic        div_ready_w;
  logic        clk_out_w;
  logic        tick_w;
  logic        running_w;
  logic [3:0]  periods_w;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  clk_div_gen #(
    .CNT_W       (16),
    .DEFAULT_DIV (4),
    .PER_W       (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_val   (div_val),
    .div_load  (div_load),
    .div_ready (div_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .periods   (periods)
  );

  clk_div_gen #(
    .CNT_W       (16),
    .DEFAULT_DIV (2),
    .PER_W       (4)
  ) dut_w (
    .clk       (clk),
    .rst       (rst),
    .en        (en_w),
    .div_val   (div_val_w),
    .div_load  (div_load_w),
    .div_ready (div_ready_w),
    .clk_out   (clk_out_w),
    .tick      (tick_w),
    .running   (running_w),
    .periods   (periods_w)
  );

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    en         = 1'b0;
    div_val    = 16'd0;
    div_load   = 1'b0;
    en_w       = 1'b0;
    div_val_w  = 16'd0;
    div_load_w = 1'b0;
    step();
    step();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_clk_out got %b exp 0", clk_out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got %b exp 0", tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL reset_running got %b exp 0", running); end
    checks++; if (div_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_div_ready got %b exp 1", div_ready); end
    checks++; if (periods !== 32'd0) begin errors++; $display("[TB] FAIL reset_periods got %0d exp 0", periods); end
    rst = 1'b0;
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL idle_running got %b exp 0", running); end
  endtask

  // N=4: clk_out 1,1,0,0; tick on count 3; periods steps on the edge after each tick.
  task automatic test_default_div();
    logic        exp_clk;
    logic        exp_tick;
    logic [31:0] exp_per;
    en = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      step();
      exp_clk  = ((i % 4) < 2) ? 1'b1 : 1'b0;
      exp_tick = ((i % 4) == 3) ? 1'b1 : 1'b0;
      exp_per  = 32'(i / 4);
      checks++; if (clk_out !== exp_clk) begin errors++; $display("[TB] FAIL div4_clk_out i=%0d got %b exp %b", i, clk_out, exp_clk); end
      checks++; if (tick !== exp_tick) begin errors++; $display("[TB] FAIL div4_tick i=%0d got %b exp %b", i, tick, exp_tick); end
      checks++; if (periods !== exp_per) begin errors++; $display("[TB] FAIL div4_periods i=%0d got %0d exp %0d", i, periods, exp_per); end
    end
    checks++; if (running !== 1'b1) begin errors++; $display("[TB] FAIL div4_running got %b exp 1", running); end
  endtask

  task automatic test_reload();
    logic exp_clk;
    logic exp_tick;
    step();
    div_val  = 16'd5;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++; if (div_ready !== 1'b0) begin errors++; $display("[TB] FAIL reload_ready_drop got %b exp 0", div_ready); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("[TB] FAIL reload_old_c2 got %b exp 0", clk_out); end
    step();
    checks++; if (tick !== 1'b1) begin errors++; $display("[TB] FAIL reload_old_tick got %b exp 1", tick); end
    checks++; if (div_ready !== 1'b0) begin errors++; $display("[TB] FAIL reload_ready_hold got %b exp 0", div_ready); end
    step();
    for (int j = 0; j <= 9; j++) begin
      if (j > 0) step();
      exp_clk  = ((j % 5) < 3) ? 1'b1 : 1'b0;
      exp_tick = ((j % 5) == 4) ? 1'b1 : 1'b0;
      checks++; if (clk_out !== exp_clk) begin errors++; $display("[TB] FAIL div5_clk_out j=%0d got %b exp %b", j, clk_out, exp_clk); end
      checks++; if (tick !== exp_tick) begin errors++; $display("[TB] FAIL div5_tick j=%0d got %b exp %b", j, tick, exp_tick); end
      checks++; if (div_ready !== 1'b1) begin errors++; $display("[TB] FAIL div5_ready j=%0d got %b exp 1", j, div_ready); end
    end
  endtask

  task automatic test_clamp();
    logic exp_clk;
    logic exp_tick;
    en = 1'b0;
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL clamp_stop_running got %b exp 0", running); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("[TB] FAIL clamp_stop_clk_out got %b exp 0", clk_out); end
    for (int v = 0; v <= 1; v++) begin
      div_val  = 16'(v);
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      checks++; if (div_ready !== 1'b1) begin errors++; $display("[TB] FAIL clamp_ready v=%0d got %b exp 1", v, div_ready); end
      checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL clamp_idle v=%0d got %b exp 0", v, running); end
      en = 1'b1;
      for (int m = 0; m <= 3; m++) begin
        step();
        exp_clk  = ((m % 2) == 0) ? 1'b1 : 1'b0;
        exp_tick = ((m % 2) == 1) ? 1'b1 : 1'b0;
        checks++; if (clk_out !== exp_clk) begin errors++; $display("[TB] FAIL clamp_clk_out v=%0d m=%0d got %b exp %b", v, m, clk_out, exp_clk); end
        checks++; if (tick !== exp_tick) begin errors++; $display("[TB] FAIL clamp_tick v=%0d m=%0d got %b exp %b", v, m, tick, exp_tick); end
      end
      en = 1'b0;
      step();
      checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL clamp_restop v=%0d got %b exp 0", v, running); end
    end
    // 0x0100 has a zero low byte; a narrowed compare would clamp it to 2.
    div_val  = 16'h0100;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    en = 1'b1;
    step();
    step();
    checks++; if (clk_out !== 1'b1) begin errors++; $display("[TB] FAIL clamp_wide_clk_out got %b exp 1", clk_out); end
    en = 1'b0;
    for (int t = 0; t < 300 && running; t++) step();
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL clamp_wide_stop_timeout got %b exp 0", running); end
  endtask

  task automatic test_stop_mid();
    logic exp_clk;
    logic exp_tick;
    div_val  = 16'd6;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      step();
      exp_clk  = (c < 3) ? 1'b1 : 1'b0;
      exp_tick = (c == 5) ? 1'b1 : 1'b0;
      checks++; if (running !== 1'b1) begin errors++; $display("[TB] FAIL stop_mid_running c=%0d got %b exp 1", c, running); end
      checks++; if (clk_out !== exp_clk) begin errors++; $display("[TB] FAIL stop_mid_clk_out c=%0d got %b exp %b", c, clk_out, exp_clk); end
      checks++; if (tick !== exp_tick) begin errors++; $display("[TB] FAIL stop_mid_tick c=%0d got %b exp %b", c, tick, exp_tick); end
    end
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL stop_mid_end_running got %b exp 0", running); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("[TB] FAIL stop_mid_end_clk_out got %b exp 0", clk_out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("[TB] FAIL stop_mid_end_tick got %b exp 0", tick); end
    // Reload to N=3 and drop en while the reload is pending.
    en = 1'b1;
    step();
    step();
    div_val  = 16'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    en = 1'b0;
    checks++; if (div_ready !== 1'b0) begin errors++; $display("[TB] FAIL reload_stop_ready got %b exp 0", div_ready); end
    step();
    step();
    step();
    checks++; if (tick !== 1'b1) begin errors++; $display("[TB] FAIL reload_stop_tick got %b exp 1", tick); end
    checks++; if (running !== 1'b1) begin errors++; $display("[TB] FAIL reload_stop_running got %b exp 1", running); end
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL reload_stop_end_running got %b exp 0", running); end
    checks++; if (div_ready !== 1'b1) begin errors++; $display("[TB] FAIL reload_stop_end_ready got %b exp 1", div_ready); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("[TB] FAIL reload_stop_end_clk_out got %b exp 0", clk_out); end
    en = 1'b1;
    step();
    step();
    step();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("[TB] FAIL div3_c2_clk_out got %b exp 0", clk_out); end
    checks++; if (tick !== 1'b1) begin errors++; $display("[TB] FAIL div3_c2_tick got %b exp 1", tick); end
  endtask

  task automatic test_async_reset();
    logic exp_clk;
    logic exp_tick;
    step();
    div_val  = 16'd7;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++; if (div_ready !== 1'b0) begin errors++; $display("[TB] FAIL areset_pre_ready got %b exp 0", div_ready); end
    checks++; if (clk_out !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_clk_out got %b exp 1", clk_out); end
    #4;
    rst = 1'b1;
    #2;
    checks++; if (clk_out !== 1'b0) begin errors++; $display("[TB] FAIL areset_clk_out got %b exp 0", clk_out); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL areset_running got %b exp 0", running); end
    checks++; if (div_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_ready got %b exp 1", div_ready); end
    checks++; if (tick !== 1'b0) begin errors++; $display("[TB] FAIL areset_tick got %b exp 0", tick); end
    checks++; if (periods !== 32'd0) begin errors++; $display("[TB] FAIL areset_periods got %0d exp 0", periods); end
    #1;
    rst = 1'b0;
    step();
    for (int i = 0; i <= 7; i++) begin
      if (i > 0) step();
      exp_clk  = ((i % 4) < 2) ? 1'b1 : 1'b0;
      exp_tick = ((i % 4) == 3) ? 1'b1 : 1'b0;
      checks++; if (clk_out !== exp_clk) begin errors++; $display("[TB] FAIL areset_div4_clk_out i=%0d got %b exp %b", i, clk_out, exp_clk); end
      checks++; if (tick !== exp_tick) begin errors++; $display("[TB] FAIL areset_div4_tick i=%0d got %b exp %b", i, tick, exp_tick); end
    end
    checks++; if (periods !== 32'd1) begin errors++; $display("[TB] FAIL areset_div4_periods got %0d exp 1", periods); end
    en = 1'b0;
  endtask

  // PER_W=4, N=2: periods climbs to 15 and wraps to 0 on the 16th period.
  task automatic test_period_wrap();
    logic [3:0] exp_per;
    logic       exp_tick;
    en_w = 1'b1;
    for (int i = 0; i <= 33; i++) begin
      step();
      exp_per  = 4'((i / 2) % 16);
      exp_tick = ((i % 2) == 1) ? 1'b1 : 1'b0;
      checks++; if (periods_w !== exp_per) begin errors++; $display("[TB] FAIL wrap_periods i=%0d got %0d exp %0d", i, periods_w, exp_per); end
      checks++; if (tick_w !== exp_tick) begin errors++; $display("[TB] FAIL wrap_tick i=%0d got %b exp %b", i, tick_w, exp_tick); end
    end
    en_w = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_reload();
    test_clamp();
    test_stop_mid();
    test_async_reset();
    test_period_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Programmable integer clock divider fed directly by the bench/system clock `clk`. It produces a registered divided clock, a one-cycle period tick, and a period counter for downstream logic. The divide ratio is reloaded through a ready/load handshake and takes effect only on a period boundary. It is the first consumer of the free-running 50% `clk` source and supplies the slow clock and enable used by later stages.

## Interface
- `CNT_W`, 16: width of the divide ratio and the phase counter.
- `DEFAULT_DIV`, 4: divide ratio loaded at reset; must be ≥ 2.
- `PER_W`, 32: width of the period counter.

- `clk` input 1: sole clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: run request; level-sensitive.
- `div_val` input CNT_W: requested divide ratio N.
- `div_load` input 1: load strobe; accepted when `div_load && div_ready`.
- `div_ready` output 1: divider can accept a new ratio.
- `clk_out` output 1: divided clock, registered.
- `tick` output 1: one-cycle pulse in the last `clk` cycle of each divided period.
- `running` output 1: divider is in RUN or RELOAD.
- `periods` output PER_W: count of completed periods since reset; wraps modulo 2^PER_W.

## Operation
- FSM states:
  - STOP: counter held at 0; `clk_out`=0; `div_ready`=1.
  - RUN: counter increments 0..N-1 and wraps.
  - RELOAD: new ratio is pending; `div_ready`=0; apply at the period boundary.
- Transitions:
  - STOP→RUN when `en`=1.
  - RUN→STOP at a period boundary (count==N-1) when `en`=0. A period is never truncated.
  - RUN→RELOAD on an accepted load.
  - RELOAD→RUN at the boundary. The pending ratio becomes N, and the counter restarts at 0.
  - RELOAD→STOP at the boundary when `en`=0. The ratio is still applied.
- Load in STOP: N updates on the next edge; `div_ready` stays 1.
- Ratio clamp: a `div_val` of 0 or 1 is stored as 2. The clamp uses a full CNT_W compare; no truncation.
- `clk_out`: 1 while count < ceil(N/2), else 0.
  - Odd N gives a high phase one cycle longer than the low phase.
- `tick`: 1 exactly when in RUN/RELOAD and count==N-1.
- `periods`: increments on every `tick` cycle.
- Simultaneous events:
  - Load accepted in the same cycle as a boundary in RUN: the new ratio takes effect at the next boundary, not this one.
  - `en` falling during RELOAD: the reload completes, then the block stops.
- Reset (async, any time): state=STOP, N=DEFAULT_DIV, count=0, `clk_out`=0, `tick`=0, `running`=0, `div_ready`=1, `periods`=0. Mid-period reset discards the pending ratio.

## Timing
- `en` sampled 1 at edge k: `running`=1 and `clk_out`=1 after edge k.
  - The first `tick` is valid after edge k+N-1.
  - `clk_out` falls after edge k+ceil(N/2).
- All outputs are registered; no combinational input-to-output path.
- Load accepted at edge j in RUN: `div_ready`=0 after edge j.
  - It returns to 1 after the edge that closes the current period, which is also the edge where count restarts at 0 with the new N.
- Divided period is exactly N `clk` cycles. With `clk` period 20, N=4 gives an 80-unit `clk_out` period.
- STOP→RUN restart latency is 1 edge. RUN→STOP latency is up to N edges.

## Structure
- Shared package `clk_div_pkg`:
  - FSM state enum (STOP, RUN, RELOAD).
  - `DIV_MIN`=2.
  - Function `clamp_div(value)`.
- Sub-module `clk_div_phase`: counter plus `clk_out`/`tick` decode, given N and a run enable.
- The top level holds the FSM, ratio/pending registers, handshake and `periods`.
- Target size is about 150–250 RTL lines.

## Test plan
- Reset then `en`=1 with DEFAULT_DIV=4:
  - `clk_out` pattern is 1,1,0,0 repeating.
  - `tick` appears every 4th cycle.
  - `periods` reads 3 after 12 cycles.
- Load `div_val`=5 while running N=4, mid-period:
  - `div_ready` drops.
  - The current period finishes with 4 cycles.
  - Then the pattern is 1,1,1,0,0 and `div_ready` returns to 1 at the boundary.
- Load `div_val`=0 and `div_val`=1 in STOP, then run: behaves as N=2, giving a `clk_out` toggle every cycle and `tick` every 2 cycles.
- Drop `en` at count 1 of N=6:
  - `clk_out`/`tick` continue to count 5, the final `tick` fires, then `running`=0 and `clk_out`=0.
  - Load together with `en`=0 during RELOAD: stops, and the next run uses the new N.
- Assert `rst` asynchronously mid-period during RELOAD:
  - All outputs go to reset values immediately, without waiting for a `clk` edge.
  - N=DEFAULT_DIV and the pending ratio is discarded.
- Preload `periods` near its limit (small PER_W=4 build): 16 periods wrap it to 0 with no glitch on `tick`.
